// File: rtl/vga_sync_monitor.sv
// vga_sync_monitor: measures hsync/vsync timing against the expected raster,
// counts frames, keeps sticky timing-error flags and reports lock once enough
// consecutive clean frames have been seen.
//
// state    | meaning
// SEARCH   | waiting for the first vsync leading edge, no errors flagged
// ACQUIRE  | counting consecutive error-free frames toward lock
// LOCKED   | timing matches parameters, locked asserted
module vga_sync_monitor #(
    parameter int H_TOTAL         = 800,
    parameter int H_SYNC          = 96,
    parameter int V_TOTAL         = 525,
    parameter int V_SYNC          = 2,
    parameter int SYNC_ACTIVE_LOW = 1,
    parameter int LOCK_FRAMES     = 2,
    parameter int FRAME_COUNT_W   = 16,
    parameter int CNT_W           = 12
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     hsync,
    input  logic                     vsync,
    input  logic                     err_clr,
    output logic [FRAME_COUNT_W-1:0] frame_count,
    output logic                     frame_done,
    output logic [CNT_W-1:0]         line_len,
    output logic                     hsync_err,
    output logic                     vsync_err,
    output logic                     locked
);

    localparam logic [1:0] S_SEARCH  = 2'd0;
    localparam logic [1:0] S_ACQUIRE = 2'd1;
    localparam logic [1:0] S_LOCKED  = 2'd2;

    localparam int GOOD_W = (LOCK_FRAMES < 2) ? 1 : $clog2(LOCK_FRAMES + 1);
    localparam logic [GOOD_W-1:0] GOOD_TGT = GOOD_W'(LOCK_FRAMES);
    localparam logic [CNT_W-1:0]  CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);

    logic              hs_n, vs_n, hs_q, vs_q;
    logic              hs_rise, hs_fall, vs_rise, vs_fall;
    logic [CNT_W-1:0]  h_cnt, w_cnt, l_cnt, vw_cnt;
    logic              h_seen, w_valid, v_seen, vw_valid;
    logic              h_bad, v_bad, h_err_ev, v_err_ev, any_err;
    logic [1:0]        state, state_nxt;
    logic [GOOD_W-1:0] good_cnt, good_nxt;
    logic              frame_ok, frame_ok_nxt;

    // Normalise both syncs so that 1 always means "pulse active".
    assign hs_n = (SYNC_ACTIVE_LOW != 0) ? ~hsync : hsync;
    assign vs_n = (SYNC_ACTIVE_LOW != 0) ? ~vsync : vsync;

    assign hs_rise = hs_n & ~hs_q;
    assign hs_fall = ~hs_n & hs_q;
    assign vs_rise = vs_n & ~vs_q;
    assign vs_fall = ~vs_n & vs_q;

    // Raw timing violations; masked while searching since nothing is trusted yet.
    always_comb begin
        h_bad = 1'b0;
        v_bad = 1'b0;
        if (hs_rise && h_seen && (h_cnt != CNT_W'(H_TOTAL)))   h_bad = 1'b1;
        if (hs_fall && w_valid && (w_cnt != CNT_W'(H_SYNC)))   h_bad = 1'b1;
        if (h_cnt == CNT_MAX)                                  h_bad = 1'b1;
        if (vs_rise && v_seen && (l_cnt != CNT_W'(V_TOTAL)))   v_bad = 1'b1;
        if (vs_fall && vw_valid && (vw_cnt != CNT_W'(V_SYNC))) v_bad = 1'b1;
        if (l_cnt == CNT_MAX)                                  v_bad = 1'b1;
    end

    assign h_err_ev = h_bad & (state != S_SEARCH);
    assign v_err_ev = v_bad & (state != S_SEARCH);
    assign any_err  = h_err_ev | v_err_ev;

    // Sync registers, timing counters, frame counter and sticky error flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hs_q        <= 1'b0;
            vs_q        <= 1'b0;
            h_cnt       <= '0;
            w_cnt       <= '0;
            l_cnt       <= '0;
            vw_cnt      <= '0;
            h_seen      <= 1'b0;
            w_valid     <= 1'b0;
            v_seen      <= 1'b0;
            vw_valid    <= 1'b0;
            line_len    <= '0;
            frame_count <= '0;
            frame_done  <= 1'b0;
            hsync_err   <= 1'b0;
            vsync_err   <= 1'b0;
        end else begin
            hs_q <= hs_n;
            vs_q <= vs_n;

            if (hs_rise) begin
                h_cnt  <= CNT_ONE;
                h_seen <= 1'b1;
                if (h_seen) line_len <= h_cnt;
            end else if (h_cnt != CNT_MAX) begin
                h_cnt <= h_cnt + CNT_ONE;
            end

            if (hs_rise) begin
                w_cnt   <= CNT_ONE;
                w_valid <= 1'b1;
            end else if (hs_n && (w_cnt != CNT_MAX)) begin
                w_cnt <= w_cnt + CNT_ONE;
            end

            // A coincident hsync edge is the first line of the new frame.
            if (vs_rise) begin
                l_cnt  <= hs_rise ? CNT_ONE : '0;
                v_seen <= 1'b1;
            end else if (hs_rise && (l_cnt != CNT_MAX)) begin
                l_cnt <= l_cnt + CNT_ONE;
            end

            if (vs_rise) begin
                vw_cnt   <= hs_rise ? CNT_ONE : '0;
                vw_valid <= 1'b1;
            end else if (vs_fall) begin
                vw_valid <= 1'b0;
            end else if (vs_n && hs_rise && (vw_cnt != CNT_MAX)) begin
                vw_cnt <= vw_cnt + CNT_ONE;
            end

            frame_done <= vs_rise;
            if (vs_rise) frame_count <= frame_count + FRAME_COUNT_W'(1);

            // A new error wins over a simultaneous clear.
            hsync_err <= h_err_ev | (hsync_err & ~err_clr);
            vsync_err <= v_err_ev | (vsync_err & ~err_clr);
        end
    end

    // Lock FSM next-state: frames are judged when their closing vsync edge arrives.
    always_comb begin
        state_nxt    = state;
        good_nxt     = good_cnt;
        frame_ok_nxt = frame_ok;
        case (state)
            S_SEARCH: begin
                if (vs_rise) begin
                    state_nxt    = S_ACQUIRE;
                    good_nxt     = '0;
                    frame_ok_nxt = 1'b1;
                end
            end
            S_ACQUIRE: begin
                if (vs_rise) begin
                    frame_ok_nxt = 1'b1;
                    if (any_err) begin
                        good_nxt = '0;
                    end else if (frame_ok) begin
                        if ((good_cnt + GOOD_W'(1)) == GOOD_TGT) begin
                            state_nxt = S_LOCKED;
                            good_nxt  = '0;
                        end else begin
                            good_nxt = good_cnt + GOOD_W'(1);
                        end
                    end
                end else if (any_err) begin
                    good_nxt     = '0;
                    frame_ok_nxt = 1'b0;
                end
            end
            S_LOCKED: begin
                if (any_err) begin
                    state_nxt    = S_ACQUIRE;
                    good_nxt     = '0;
                    frame_ok_nxt = vs_rise;
                end
            end
            default: begin
                state_nxt    = S_SEARCH;
                good_nxt     = '0;
                frame_ok_nxt = 1'b0;
            end
        endcase
    end

    // Lock FSM state and registered locked output.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_SEARCH;
            good_cnt <= '0;
            frame_ok <= 1'b0;
            locked   <= 1'b0;
        end else begin
            state    <= state_nxt;
            good_cnt <= good_nxt;
            frame_ok <= frame_ok_nxt;
            locked   <= (state_nxt == S_LOCKED);
        end
    end

endmodule

// File: tb/tb_vga_sync_monitor.sv
// Testbench for vga_sync_monitor using a scaled-down raster (40x12 clocks/lines)
// so that many frames fit in a short run. Expected lock state is tracked at
// frame granularity from the lock rules; frame counts are tracked by the bench.
module tb_vga_sync_monitor;

    localparam int H_T  = 40;
    localparam int H_S  = 6;
    localparam int V_T  = 12;
    localparam int V_S  = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic hs_a = 1'b0;
    logic vs_a = 1'b0;
    logic err_clr = 1'b0;
    logic hs_l, vs_l;

    assign hs_l = ~hs_a;
    assign vs_l = ~vs_a;

    logic [15:0] m_fc, h_fc, n_fc;
    logic [1:0]  f_fc;
    logic        m_fd, h_fd, n_fd, f_fd;
    logic [11:0] m_ll, h_ll, n_ll, f_ll;
    logic        m_he, h_he, n_he, f_he;
    logic        m_ve, h_ve, n_ve, f_ve;
    logic        m_lk, h_lk, n_lk, f_lk;

    int checks = 0;
    int errors = 0;
    int nframes = 0;
    int fd_main = 0;
    int fd_fc = 0;
    bit neg_locked_seen = 1'b0;

    always #5 clk = ~clk;

    vga_sync_monitor #(.H_TOTAL(H_T), .H_SYNC(H_S), .V_TOTAL(V_T), .V_SYNC(V_S),
                       .SYNC_ACTIVE_LOW(1)) u_main (
        .clk(clk), .rst(rst), .hsync(hs_l), .vsync(vs_l), .err_clr(err_clr),
        .frame_count(m_fc), .frame_done(m_fd), .line_len(m_ll),
        .hsync_err(m_he), .vsync_err(m_ve), .locked(m_lk));

    vga_sync_monitor #(.H_TOTAL(H_T), .H_SYNC(H_S), .V_TOTAL(V_T), .V_SYNC(V_S),
                       .SYNC_ACTIVE_LOW(0)) u_hi (
        .clk(clk), .rst(rst), .hsync(hs_a), .vsync(vs_a), .err_clr(err_clr),
        .frame_count(h_fc), .frame_done(h_fd), .line_len(h_ll),
        .hsync_err(h_he), .vsync_err(h_ve), .locked(h_lk));

    vga_sync_monitor #(.H_TOTAL(H_T), .H_SYNC(H_S), .V_TOTAL(V_T), .V_SYNC(V_S),
                       .SYNC_ACTIVE_LOW(1)) u_neg (
        .clk(clk), .rst(rst), .hsync(hs_a), .vsync(vs_a), .err_clr(err_clr),
        .frame_count(n_fc), .frame_done(n_fd), .line_len(n_ll),
        .hsync_err(n_he), .vsync_err(n_ve), .locked(n_lk));

    vga_sync_monitor #(.H_TOTAL(H_T), .H_SYNC(H_S), .V_TOTAL(V_T), .V_SYNC(V_S),
                       .SYNC_ACTIVE_LOW(1), .FRAME_COUNT_W(2)) u_fc (
        .clk(clk), .rst(rst), .hsync(hs_l), .vsync(vs_l), .err_clr(err_clr),
        .frame_count(f_fc), .frame_done(f_fd), .line_len(f_ll),
        .hsync_err(f_he), .vsync_err(f_ve), .locked(f_lk));

    // frame_done pulse counters and a watch on the wrong-polarity instance
    always @(negedge clk) begin
        if (rst) begin
            fd_main = 0;
            fd_fc   = 0;
        end else begin
            if (m_fd) fd_main++;
            if (f_fd) fd_fc++;
        end
        if (n_lk) neg_locked_seen = 1'b1;
    end

    task automatic send_line(input int len, input int hsw, input logic vact, input int clr_at);
        for (int i = 0; i < len; i++) begin
            @(negedge clk);
            hs_a    = (i < hsw);
            vs_a    = vact;
            err_clr = (i == clr_at);
        end
    endtask

    task automatic send_lines(input int first, input int last, input int short_idx,
                              input int wide_idx, input int vlines,
                              input int clr_line, input int clr_at);
        for (int l = first; l <= last; l++) begin
            if (l == 0) nframes++;
            send_line((l == short_idx) ? H_T - 1 : H_T,
                      (l == wide_idx) ? H_S + 1 : H_S,
                      (l < vlines),
                      (l == clr_line) ? clr_at : -1);
        end
    endtask

    task automatic send_frame(input int short_idx, input int wide_idx, input int vlines);
        send_lines(0, V_T - 1, short_idx, wide_idx, vlines, -1, 0);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (m_fc !== 16'd0) begin errors++; $display("FAIL reset_frame_count: got %0d expected 0", m_fc); end
        checks++; if (m_fd !== 1'b0) begin errors++; $display("FAIL reset_frame_done: got %0b expected 0", m_fd); end
        checks++; if (m_ll !== 12'd0) begin errors++; $display("FAIL reset_line_len: got %0d expected 0", m_ll); end
        checks++; if (m_he !== 1'b0) begin errors++; $display("FAIL reset_hsync_err: got %0b expected 0", m_he); end
        checks++; if (m_ve !== 1'b0) begin errors++; $display("FAIL reset_vsync_err: got %0b expected 0", m_ve); end
        checks++; if (m_lk !== 1'b0) begin errors++; $display("FAIL reset_locked: got %0b expected 0", m_lk); end
        rst = 1'b0;
        nframes = 0;
    endtask

    task automatic test_lock();
        repeat (3) send_frame(-1, -1, V_S);
        checks++; if (m_lk !== 1'b1) begin errors++; $display("FAIL lock_locked: got %0b expected 1", m_lk); end
        checks++; if (m_fc !== 16'(nframes)) begin errors++; $display("FAIL lock_frame_count: got %0d expected %0d", m_fc, nframes); end
        checks++; if (m_he !== 1'b0) begin errors++; $display("FAIL lock_hsync_err: got %0b expected 0", m_he); end
        checks++; if (m_ve !== 1'b0) begin errors++; $display("FAIL lock_vsync_err: got %0b expected 0", m_ve); end
        checks++; if (m_ll !== 12'(H_T)) begin errors++; $display("FAIL lock_line_len: got %0d expected %0d", m_ll, H_T); end
    endtask

    task automatic test_polarity();
        checks++; if (h_lk !== 1'b1) begin errors++; $display("FAIL pol_high_locked: got %0b expected 1", h_lk); end
        checks++; if (h_fc !== 16'(nframes)) begin errors++; $display("FAIL pol_high_frame_count: got %0d expected %0d", h_fc, nframes); end
        checks++; if (neg_locked_seen !== 1'b0) begin errors++; $display("FAIL pol_wrong_locked: got %0b expected 0", neg_locked_seen); end
    endtask

    task automatic test_frame_count();
        repeat (2) send_frame(-1, -1, V_S);
        checks++; if (f_fc !== 2'(nframes)) begin errors++; $display("FAIL fc_wrap: got %0d expected %0d", f_fc, nframes % 4); end
        checks++; if (fd_fc !== nframes) begin errors++; $display("FAIL fc_done_pulses: got %0d expected %0d", fd_fc, nframes); end
        checks++; if (fd_main !== nframes) begin errors++; $display("FAIL main_done_pulses: got %0d expected %0d", fd_main, nframes); end
        checks++; if (m_fc !== 16'(nframes)) begin errors++; $display("FAIL fc_main_count: got %0d expected %0d", m_fc, nframes); end
    endtask

    task automatic test_short_line();
        int idx;
        idx = int'($urandom_range(0, V_T - 3));
        for (int l = 0; l < V_T; l++) begin
            send_lines(l, l, idx, -1, V_S, -1, 0);
            if (l == idx + 1) begin
                checks++; if (m_he !== 1'b1) begin errors++; $display("FAIL short_hsync_err: got %0b expected 1", m_he); end
                checks++; if (m_ll !== 12'(H_T - 1)) begin errors++; $display("FAIL short_line_len: got %0d expected %0d", m_ll, H_T - 1); end
                checks++; if (m_lk !== 1'b0) begin errors++; $display("FAIL short_locked: got %0b expected 0", m_lk); end
                checks++; if (m_ve !== 1'b0) begin errors++; $display("FAIL short_vsync_err: got %0b expected 0", m_ve); end
            end
        end
        repeat (2) send_frame(-1, -1, V_S);
        checks++; if (m_lk !== 1'b0) begin errors++; $display("FAIL short_relock_early: got %0b expected 0", m_lk); end
        send_frame(-1, -1, V_S);
        checks++; if (m_lk !== 1'b1) begin errors++; $display("FAIL short_relock: got %0b expected 1", m_lk); end
    endtask

    task automatic test_vsync_width_clr();
        int clr_pt;
        send_frame(-1, -1, 3);
        checks++; if (m_ve !== 1'b1) begin errors++; $display("FAIL vwide_vsync_err: got %0b expected 1", m_ve); end
        checks++; if (m_lk !== 1'b0) begin errors++; $display("FAIL vwide_locked: got %0b expected 0", m_lk); end
        clr_pt = int'($urandom_range(1, H_T - 2));
        for (int l = 0; l < V_T; l++) begin
            send_lines(l, l, -1, -1, V_S, 5, clr_pt);
            if (l == 5) begin
                checks++; if (m_ve !== 1'b0) begin errors++; $display("FAIL clr_vsync_err: got %0b expected 0", m_ve); end
                checks++; if (m_he !== 1'b0) begin errors++; $display("FAIL clr_hsync_err: got %0b expected 0", m_he); end
            end
        end
        for (int l = 0; l < V_T; l++) begin
            send_lines(l, l, -1, -1, 3, 3, 0);
            if (l == 3) begin
                checks++; if (m_ve !== 1'b1) begin errors++; $display("FAIL clr_vs_new_err: got %0b expected 1", m_ve); end
                checks++; if (m_he !== 1'b0) begin errors++; $display("FAIL clr_vs_new_herr: got %0b expected 0", m_he); end
            end
        end
    endtask

    task automatic test_random();
        int m_state, m_good, kind, sidx, widx, vl, cl_line, cl_at;
        bit m_cur_bad, bad, exp_h, exp_v;
        m_state = 1; m_good = 0; m_cur_bad = 1'b1; exp_h = 1'b0; exp_v = 1'b1;
        for (int f = 0; f < 8; f++) begin
            kind = int'($urandom_range(0, 5));
            sidx = -1; widx = -1; vl = V_S; bad = 1'b0; cl_line = -1; cl_at = 0;
            case (kind)
                0: begin sidx = int'($urandom_range(0, V_T - 2)); bad = 1'b1; exp_h = 1'b1; end
                1: begin widx = int'($urandom_range(0, V_T - 1)); bad = 1'b1; exp_h = 1'b1; end
                2: begin vl = 3; bad = 1'b1; exp_v = 1'b1; end
                default: begin
                    if ($urandom_range(0, 1) == 1) begin
                        cl_line = 5; cl_at = int'($urandom_range(1, H_T - 2));
                        exp_h = 1'b0; exp_v = 1'b0;
                    end
                end
            endcase
            // previous frame is judged at this frame's leading vsync edge
            if (m_state == 1 && !m_cur_bad) begin
                m_good++;
                if (m_good == 2) m_state = 2;
            end
            m_cur_bad = bad;
            if (bad) begin m_state = 1; m_good = 0; end
            send_lines(0, V_T - 1, sidx, widx, vl, cl_line, cl_at);
            checks++; if (m_lk !== (m_state == 2)) begin errors++; $display("FAIL rand_locked f%0d kind%0d: got %0b expected %0b", f, kind, m_lk, (m_state == 2)); end
            checks++; if (m_he !== exp_h) begin errors++; $display("FAIL rand_hsync_err f%0d kind%0d: got %0b expected %0b", f, kind, m_he, exp_h); end
            checks++; if (m_ve !== exp_v) begin errors++; $display("FAIL rand_vsync_err f%0d kind%0d: got %0b expected %0b", f, kind, m_ve, exp_v); end
            checks++; if (m_fc !== 16'(nframes)) begin errors++; $display("FAIL rand_frame_count f%0d: got %0d expected %0d", f, m_fc, nframes); end
        end
    endtask

    task automatic test_reset_midframe();
        repeat (3) send_frame(-1, -1, V_S);
        send_lines(0, 5, -1, -1, V_S, -1, 0);
        checks++; if (m_lk !== 1'b1) begin errors++; $display("FAIL mid_pre_locked: got %0b expected 1", m_lk); end
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        checks++; if (m_fc !== 16'd0) begin errors++; $display("FAIL mid_frame_count: got %0d expected 0", m_fc); end
        checks++; if (m_fd !== 1'b0) begin errors++; $display("FAIL mid_frame_done: got %0b expected 0", m_fd); end
        checks++; if (m_ll !== 12'd0) begin errors++; $display("FAIL mid_line_len: got %0d expected 0", m_ll); end
        checks++; if (m_he !== 1'b0) begin errors++; $display("FAIL mid_hsync_err: got %0b expected 0", m_he); end
        checks++; if (m_ve !== 1'b0) begin errors++; $display("FAIL mid_vsync_err: got %0b expected 0", m_ve); end
        checks++; if (m_lk !== 1'b0) begin errors++; $display("FAIL mid_locked: got %0b expected 0", m_lk); end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        nframes = 0;
        send_lines(6, V_T - 1, -1, -1, V_S, -1, 0);
        repeat (2) send_frame(-1, -1, V_S);
        checks++; if (m_lk !== 1'b0) begin errors++; $display("FAIL mid_relock_early: got %0b expected 0", m_lk); end
        send_frame(-1, -1, V_S);
        checks++; if (m_lk !== 1'b1) begin errors++; $display("FAIL mid_relock: got %0b expected 1", m_lk); end
        checks++; if (m_fc !== 16'(nframes)) begin errors++; $display("FAIL mid_frame_count_after: got %0d expected %0d", m_fc, nframes); end
        checks++; if (m_ll !== 12'(H_T)) begin errors++; $display("FAIL mid_line_len_after: got %0d expected %0d", m_ll, H_T); end
    endtask

    task automatic test_wrong_polarity();
        checks++; if (neg_locked_seen !== 1'b0) begin errors++; $display("FAIL wrong_pol_ever_locked: got %0b expected 0", neg_locked_seen); end
        checks++; if (h_lk !== 1'b1) begin errors++; $display("FAIL high_pol_final_locked: got %0b expected 1", h_lk); end
    endtask

    initial begin
        test_reset();
        test_lock();
        test_polarity();
        test_frame_count();
        test_short_line();
        test_vsync_width_clr();
        test_random();
        test_reset_midframe();
        test_wrong_polarity();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/vga_sync_monitor.md
VGA_SYNC_MONITOR -- requirements
Module: vga_sync_monitor

Interface
REQ-001 SHALL have parameter H_TOTAL, default 800, clocks per line.
REQ-002 SHALL have parameter H_SYNC, default 96, hsync pulse width in clocks.
REQ-003 SHALL have parameter V_TOTAL, default 525, lines per frame.
REQ-004 SHALL have parameter V_SYNC, default 2, vsync pulse width in lines.
REQ-005 SHALL have parameter SYNC_ACTIVE_LOW, default 1, sync polarity (1 = pulse is low).
REQ-006 SHALL have parameter LOCK_FRAMES, default 2, consecutive good frames required to lock.
REQ-007 SHALL have parameter FRAME_COUNT_W, default 16, width of frame_count.
REQ-008 SHALL have parameter CNT_W, default 12, width of line_len and the internal clock/line counters.
REQ-009 clk  input  1  sole clock, rising edge.
REQ-010 rst  input  1  reset, asynchronous, active-high.
REQ-011 hsync  input  1  horizontal sync, synchronous to clk.
REQ-012 vsync  input  1  vertical sync, synchronous to clk.
REQ-013 err_clr  input  1  clears sticky error flags.
REQ-014 frame_count  output  FRAME_COUNT_W  vsync leading edges seen, wraps.
REQ-015 frame_done  output  1  one-cycle pulse per vsync leading edge.
REQ-016 line_len  output  CNT_W  last measured line period in clocks.
REQ-017 hsync_err  output  1  sticky horizontal timing error.
REQ-018 vsync_err  output  1  sticky vertical timing error.
REQ-019 locked  output  1  timing matches parameters.

Function
REQ-020 SHALL normalise syncs to active-high internally (invert when SYNC_ACTIVE_LOW=1) and register them once. Leading edge = active now and inactive in the register.
REQ-021 h_cnt SHALL load 1 on an hsync leading edge and otherwise increment, saturating at 2^CNT_W-1.
REQ-022 On each hsync leading edge after the first, line_len SHALL load h_cnt. h_cnt != H_TOTAL SHALL flag a horizontal error.
REQ-023 SHALL count hsync active width. On the trailing edge, width != H_SYNC SHALL flag a horizontal error.
REQ-024 Lines per frame (hsync leading edges between vsync leading edges) != V_TOTAL SHALL flag a vertical error.
REQ-025 hsync leading edges during vsync active != V_SYNC SHALL flag a vertical error, checked at the vsync trailing edge.
REQ-026 h_cnt saturation SHALL flag a horizontal error; the line counter saturating SHALL flag a vertical error.
REQ-027 Each vsync leading edge SHALL increment frame_count modulo 2^FRAME_COUNT_W and pulse frame_done.
REQ-028 All outputs SHALL be registered and SHALL update on the clock edge following the clk edge that samples the triggering sync edge.
REQ-029 FSM states SHALL be SEARCH, ACQUIRE and LOCKED.
REQ-030 SEARCH: SHALL flag no errors; the first vsync leading edge SHALL transition to ACQUIRE.
REQ-031 ACQUIRE: each vsync leading edge closing an error-free frame SHALL increment good_cnt. good_cnt reaching LOCK_FRAMES SHALL transition to LOCKED. Any error SHALL clear good_cnt.
REQ-032 LOCKED: locked=1. Any error SHALL deassert locked on the next edge and transition to ACQUIRE with good_cnt=0.
REQ-033 Flagged errors SHALL set the sticky flags; err_clr SHALL clear them.
REQ-034 When err_clr and a new error occur in the same cycle, the error flag SHALL be 1.
REQ-035 Simultaneous hsync and vsync leading edges: the hsync edge SHALL count as the first line of the new frame.

Reset
REQ-036 While rst is high: frame_count=0, frame_done=0, line_len=0, hsync_err=0, vsync_err=0, locked=0, FSM=SEARCH, all counters=0, sync registers=inactive.
REQ-037 Reset asserted mid-frame SHALL take effect immediately; after release, the first frame SHALL be re-acquired from SEARCH.

Verification
REQ-038 Defaults, nominal 800/96/525/2 active-low stream -> locked=1 on the 3rd vsync leading edge, frame_count=3, errors=0, line_len=800.
REQ-039 Locked stream, one line shortened to 799 -> hsync_err=1 and line_len=799 next cycle, locked=0. After 2 further clean frames -> locked=1 again.
REQ-040 vsync width 3 lines -> vsync_err=1 after the vsync trailing edge. err_clr pulse on a clean cycle -> vsync_err=0. err_clr coincident with a new error -> flag stays 1.
REQ-041 FRAME_COUNT_W=2, 5 vsync leading edges -> frame_count=1. frame_done is 1 for exactly 5 cycles in total.
REQ-042 SYNC_ACTIVE_LOW=0 with active-high nominal stream -> lock as in REQ-038. Same stream with the default polarity -> locked never asserts.
REQ-043 rst pulsed mid-frame while locked -> all outputs 0 asynchronously. Lock re-achieved on the 3rd subsequent vsync leading edge.
